oka_seq_ctrl_64bit: RTL and testbench

- Sequencer computing a 64x64 carry-less (GF(2)[x]) product, 127-bit result, by time-sharing one external 32x32 carry-less multiplier core over three Karatsuba passes.
- Splits operands into even/odd halves and recombines with the overlap-free interleave: even bits from P0/P2, odd bits from the middle term.
- Sits between a valid/ready requester and the shared half-width multiplier core.

---
 rtl/oka_seq_ctrl_64bit.sv | 180 ++++++++++++++++++
 tb/tb_oka_seq_ctrl_64bit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/oka_seq_ctrl_64bit.sv
// 64x64 carry-less multiplier sequencer: three Karatsuba passes over one shared
// 32x32 carry-less core, recombined with an even/odd bit interleave.
module oka_seq_ctrl_64bit #(
  parameter int N     = 64,
  parameter int H     = N / 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-2:0]   out_p,
  output logic             core_start,
  output logic [H-1:0]     core_a,
  output logic [H-1:0]     core_b,
  input  logic             core_done,
  input  logic [2*H-2:0]   core_p,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    COMBINE,
    DONE
  } state_t;

  typedef logic [2*H-2:0] half_prod_t;

  state_t     state;
  logic [1:0] pass;
  logic [N-1:0] a_reg;
  logic [N-1:0] b_reg;
  half_prod_t p0;
  half_prod_t p1;
  half_prod_t p2;

  function automatic logic [H-1:0] even_bits(input logic [N-1:0] x);
    logic [H-1:0] r;
    r = '0;
    for (int k = 0; k < H; k++) r[k] = x[2*k];
    return r;
  endfunction

  function automatic logic [H-1:0] odd_bits(input logic [N-1:0] x);
    logic [H-1:0] r;
    r = '0;
    for (int k = 0; k < H; k++) r[k] = x[2*k+1];
    return r;
  endfunction

  // Pass 0 multiplies the even halves, pass 1 the folded halves, pass 2 the odd halves.
  function automatic logic [H-1:0] pass_operand(input logic [N-1:0] x, input logic [1:0] p);
    logic [H-1:0] r;
    case (p)
      2'd0:    r = even_bits(x);
      2'd1:    r = even_bits(x) ^ odd_bits(x);
      default: r = odd_bits(x);
    endcase
    return r;
  endfunction

  // A = Ae(x^2) + x*Ao(x^2): even result bits come from P0 and x^2*P2, odd bits
  // from the Karatsuba middle term, so the three pieces never overlap in a bit.
  function automatic logic [2*N-2:0] interleave(input half_prod_t q0, input half_prod_t q1,
                                                input half_prod_t q2);
    half_prod_t      mid;
    logic [2*N-2:0]  r;
    mid = q1 ^ q0 ^ q2;
    r   = '0;
    r[0] = q0[0];
    for (int k = 1; k < 2*H-1; k++) r[2*k] = q0[k] ^ q2[k-1];
    r[2*N-2] = q2[2*H-2];
    for (int k = 0; k < 2*H-1; k++) r[2*k+1] = mid[k];
    return r;
  endfunction

  // NOTE: every register here, state and datapath alike, is updated with <= so all
  // of them see pre-edge values; blocking writes would let later lines see new ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: capture registers are cleared too, so no stale product leaks out after reset.
      state      <= IDLE;
      pass       <= 2'd0;
      a_reg      <= '0;
      b_reg      <= '0;
      p0         <= '0;
      p1         <= '0;
      p2         <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_p      <= '0;
      core_start <= 1'b0;
      core_a     <= '0;
      core_b     <= '0;
      busy       <= 1'b0;
      op_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg      <= in_a;
            b_reg      <= in_b;
            pass       <= 2'd0;
            core_a     <= pass_operand(in_a, 2'd0);
            core_b     <= pass_operand(in_b, 2'd0);
            core_start <= 1'b1;
            in_ready   <= 1'b0;
            busy       <= 1'b1;
            state      <= ISSUE;
          end
        end

        ISSUE: begin
          core_start <= 1'b0;
          state      <= WAIT;
        end

        WAIT: begin
          if (core_done) begin
            case (pass)
              2'd0:    p0 <= core_p;
              2'd1:    p1 <= core_p;
              default: p2 <= core_p;
            endcase
            if (pass != 2'd2) begin
              pass       <= pass + 2'd1;
              core_a     <= pass_operand(a_reg, pass + 2'd1);
              core_b     <= pass_operand(b_reg, pass + 2'd1);
              core_start <= 1'b1;
              state      <= ISSUE;
            end else begin
              core_a <= '0;
              core_b <= '0;
              state  <= COMBINE;
            end
          end
        end

        COMBINE: begin
          out_p     <= interleave(p0, p1, p2);
          out_valid <= 1'b1;
          state     <= DONE;
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            op_count  <= op_count + CNT_W'(1);
            pass      <= 2'd0;
            state     <= IDLE;
          end
        end

        default: begin
          state      <= IDLE;
          in_ready   <= 1'b1;
          out_valid  <= 1'b0;
          core_start <= 1'b0;
          core_a     <= '0;
          core_b     <= '0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

  // The core must take at least one cycle; a completion in the start cycle is a core fault.
  a_no_done_in_issue : assert property (@(posedge clk) disable iff (rst)
    (state == ISSUE) |-> !core_done);

endmodule

// File: tb/tb_oka_seq_ctrl_64bit.sv
// Directed and random checks of the Karatsuba sequencer against a behavioural
// carry-less multiplier core model with per-pass latency.
module tb_oka_seq_ctrl_64bit;
  localparam int N     = 64;
  localparam int H     = 32;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_a;
  logic [N-1:0]     in_b;
  logic             out_valid;
  logic             out_ready;
  logic [2*N-2:0]   out_p;
  logic             core_start;
  logic [H-1:0]     core_a;
  logic [H-1:0]     core_b;
  logic             core_done;
  logic [2*H-2:0]   core_p;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  always #5 clk = ~clk;

  oka_seq_ctrl_64bit #(.N(N), .H(H), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_p      (out_p),
    .core_start (core_start),
    .core_a     (core_a),
    .core_b     (core_b),
    .core_done  (core_done),
    .core_p     (core_p),
    .busy       (busy),
    .op_count   (op_count)
  );

  int tests = 0;
  int fails = 0;
  int exp_ops = 0;

  task automatic check(input string name, input logic [2*N-2:0] got, input logic [2*N-2:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [2*H-2:0] clmul32(input logic [H-1:0] a, input logic [H-1:0] b);
    logic [2*H-2:0] r;
    r = '0;
    for (int i = 0; i < H; i++) if (b[i]) r = r ^ ((2*H-1)'(a) << i);
    return r;
  endfunction

  function automatic logic [2*N-2:0] clmul64(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [2*N-2:0] r;
    r = '0;
    for (int i = 0; i < N; i++) if (b[i]) r = r ^ ((2*N-1)'(a) << i);
    return r;
  endfunction

  // Core model: core_done pulses L cycles after the core_start cycle, L per pass.
  int          lat_cfg [3];
  int          nstart = 0;
  int          start_total = 0;
  int          spur_tog = 0;
  int          spur_seen = 0;

  initial begin
    int         cnt;
    logic       pend;
    logic [H-1:0] ca, cb;
    cnt = 0; pend = 1'b0; ca = '0; cb = '0;
    core_done = 1'b0;
    core_p    = '0;
    forever begin
      @(negedge clk);
      core_done = 1'b0;
      if (rst) begin
        pend      = 1'b0;
        nstart    = 0;
        spur_seen = spur_tog;
      end else begin
        if (pend) begin
          cnt--;
          if (cnt == 0) begin
            core_done = 1'b1;
            core_p    = clmul32(ca, cb);
            pend      = 1'b0;
          end
        end
        if (spur_tog != spur_seen) begin
          spur_seen = spur_tog;
          core_done = 1'b1;
          core_p    = '1;
        end
        if (core_start) begin
          pend = 1'b1;
          ca   = core_a;
          cb   = core_b;
          cnt  = lat_cfg[nstart % 3];
          nstart++;
          start_total++;
        end
      end
    end
  end

  // One full transaction; called and returns at a negedge.
  task automatic run_txn(input logic [N-1:0] a, input logic [N-1:0] b,
                         input int l0, input int l1, input int l2, input int hold,
                         output logic [2*N-2:0] p, output int lat, output logic stable);
    int n;
    lat_cfg[0] = l0; lat_cfg[1] = l1; lat_cfg[2] = l2;
    stable = 1'b1;
    p      = '0;
    lat    = 0;
    n      = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL in_ready_timeout: in_ready stayed 0 for %0d cycles", n);
      return;
    end
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(posedge clk);
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 200);
    if (!out_valid) begin
      tests++; fails++;
      $display("FAIL out_valid_timeout: no product after %0d cycles", lat);
      return;
    end
    p = out_p;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (out_p !== p || in_ready !== 1'b0 || out_valid !== 1'b1) stable = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    exp_ops++;
  endtask

  typedef struct {
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    int             l0;
    int             l1;
    int             l2;
    int             hold;
    logic [2*N-2:0] exp;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2*N-2:0] p;
    int             lat;
    logic           stable;
    int             s0;
    int             sc;
    int             n;
    logic [N-1:0]   ra, rb;

    vecs[0] = '{64'h1, 64'h1, 1, 1, 1, 0, 127'h1};
    vecs[1] = '{64'h3, 64'h3, 1, 1, 1, 0, 127'h5};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h3, 1, 1, 1, 0, 127'h1_0000_0000_0000_0001};
    vecs[3] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2, 2, 2, 2, 127'h1 << 126};
    vecs[4] = '{64'h0, 64'hDEAD_BEEF_CAFE_F00D, 1, 3, 2, 0, 127'h0};
    vecs[5] = '{64'h5, 64'h3, 1, 1, 1, 0, 127'hF};
    vecs[6] = '{64'h1_0000_0000, 64'h1_0000_0000, 1, 2, 1, 1, 127'h1 << 64};
    vecs[7] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1, 5, 2, 10,
                {1'b1, {63{2'b01}}}};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    lat_cfg[0] = 1; lat_cfg[1] = 1; lat_cfg[2] = 1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_core_start", core_start, 0);
    check("rst_core_ab", {core_a, core_b}, 0);
    check("rst_op_count", op_count, 0);
    check("rst_out_p", out_p, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      s0 = start_total;
      run_txn(vecs[i].a, vecs[i].b, vecs[i].l0, vecs[i].l1, vecs[i].l2, vecs[i].hold,
              p, lat, stable);
      check($sformatf("vec%0d_product", i), p, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].l0 + vecs[i].l1 + vecs[i].l2 + 5);
      check($sformatf("vec%0d_starts", i), start_total - s0, 3);
      check($sformatf("vec%0d_release", i), {out_valid, in_ready, busy}, 3'b010);
      if (vecs[i].hold > 0) check($sformatf("vec%0d_backpressure", i), stable, 1);
    end
    check("op_count_directed", op_count, exp_ops);

    // Spurious completion while idle must leave the block untouched.
    spur_tog++;
    repeat (3) @(negedge clk);
    check("spur_idle", {in_ready, busy, out_valid, core_start}, 4'b1000);
    check("spur_op_count", op_count, exp_ops);
    run_txn(64'h3, 64'h3, 1, 1, 1, 0, p, lat, stable);
    check("spur_followup", p, 127'h5);

    // Reset while waiting on the second pass.
    lat_cfg[0] = 3; lat_cfg[1] = 3; lat_cfg[2] = 3;
    in_valid = 1'b1; in_a = 64'h0123_4567_89AB_CDEF; in_b = 64'hFEDC_BA98_7654_3210;
    sc = 0; n = 0;
    while (sc < 2 && n < 100) begin
      @(negedge clk);
      in_valid = 1'b0;
      n++;
      if (core_start) sc++;
    end
    check("midrst_reached_pass1", sc, 2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_idle", {in_ready, busy, out_valid, core_start}, 4'b1000);
    check("midrst_op_count", op_count, 0);
    check("midrst_core_ab", {core_a, core_b}, 0);
    exp_ops = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_txn(64'h3, 64'h3, 1, 1, 1, 0, p, lat, stable);
    check("midrst_followup", p, 127'h5);
    check("midrst_followup_latency", lat, 8);

    // Back-to-back random operands with random consumer stalls.
    for (int i = 0; i < 1000; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      run_txn(ra, rb, $urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 4),
              $urandom_range(0, 3), p, lat, stable);
      check($sformatf("rand%0d", i), p, clmul64(ra, rb));
    end
    check("op_count_final", op_count, CNT_W'(exp_ops));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
